// File: rtl/controle_operacoes_matriz_pkg.sv
// Shared definitions for the 5x5 signed-matrix sequencer: dimensions, opcodes,
// FSM states and element range limits.
package controle_operacoes_matriz_pkg;

  localparam int N        = 5;
  localparam int DATA_W   = 8;
  localparam int OP_W     = 3;
  localparam int ROW_W    = $clog2(N);
  localparam int ROW_BITS = N * DATA_W;
  localparam int MAT_BITS = N * N * DATA_W;

  localparam logic [OP_W-1:0] OP_SOMA     = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB      = 3'b001;
  localparam logic [OP_W-1:0] OP_OPOSICAO = 3'b010;
  localparam logic [OP_W-1:0] OP_ESCALAR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } estado_t;

  // Representable element range, expressed at the wide intermediate width
  localparam logic signed [2*DATA_W-1:0] WIDE_MAX = (2**(DATA_W-1)) - 1;
  localparam logic signed [2*DATA_W-1:0] WIDE_MIN = -(2**(DATA_W-1));

  // Clamp values used when saturation is enabled
  localparam logic [DATA_W-1:0] ELEM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] ELEM_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Opcodes 000..011 are defined; everything above is rejected
  function automatic logic opcode_valido(input logic [OP_W-1:0] op);
    return (op <= OP_ESCALAR);
  endfunction

endpackage

// File: rtl/controle_operacoes_matriz_if.sv
// Command/result bundle between the command decoder (master) and the
// matrix sequencer (slave).
interface controle_operacoes_matriz_if;
  import controle_operacoes_matriz_pkg::*;

  logic                start;
  logic [OP_W-1:0]     opcode;
  logic [MAT_BITS-1:0] matrix_A;
  logic [MAT_BITS-1:0] matrix_B;
  logic [DATA_W-1:0]   escalar;
  logic [MAT_BITS-1:0] result;
  logic                busy;
  logic                done;
  logic                overflow;
  logic                erro;

  modport master (
    output start, opcode, matrix_A, matrix_B, escalar,
    input  result, busy, done, overflow, erro
  );

  modport slave (
    input  start, opcode, matrix_A, matrix_B, escalar,
    output result, busy, done, overflow, erro
  );

endinterface

// File: rtl/controle_operacoes_matriz_ula_linha.sv
// Row-wide combinational ALU: N signed elements per row.
// Build option MATRIZ_SATURATE_EN: overflowed elements clamp to the signed
// limits; without it they wrap to the low DATA_W bits.
module ula_linha
  import controle_operacoes_matriz_pkg::*;
(
  input  logic [ROW_BITS-1:0]     row_a,
  input  logic [ROW_BITS-1:0]     row_b,
  input  logic signed [DATA_W-1:0] escalar,
  input  logic [OP_W-1:0]         opcode,
  output logic [ROW_BITS-1:0]     row_res,
  output logic                    row_ovf
);

  logic [N-1:0] ovf_vec;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      logic signed [DATA_W-1:0]   a;
      logic signed [DATA_W-1:0]   b;
      logic signed [2*DATA_W-1:0] wide;
      logic                       ovf;

      assign a = row_a[gi*DATA_W +: DATA_W];
      assign b = row_b[gi*DATA_W +: DATA_W];

      // Exact result at double width, so every opcode fits before range checking
      always_comb begin
        wide = '0;
        case (opcode)
          OP_SOMA:     wide = {{DATA_W{a[DATA_W-1]}}, a} + {{DATA_W{b[DATA_W-1]}}, b};
          OP_SUB:      wide = {{DATA_W{a[DATA_W-1]}}, a} - {{DATA_W{b[DATA_W-1]}}, b};
          OP_OPOSICAO: wide = '0 - {{DATA_W{a[DATA_W-1]}}, a};
          OP_ESCALAR:  wide = a * escalar;
          default:     wide = '0;
        endcase
      end

      assign ovf = (wide > WIDE_MAX) || (wide < WIDE_MIN);
      assign ovf_vec[gi] = ovf;

`ifdef MATRIZ_SATURATE_EN
      assign row_res[gi*DATA_W +: DATA_W] = !ovf ? wide[DATA_W-1:0] :
                                            (wide[2*DATA_W-1] ? ELEM_MIN : ELEM_MAX);
`else
      assign row_res[gi*DATA_W +: DATA_W] = wide[DATA_W-1:0];
`endif
    end
  endgenerate

  assign row_ovf = |ovf_vec;

endmodule

// File: rtl/controle_operacoes_matriz.sv
// Matrix operation sequencer: latches operands on start, runs one row per
// clock through ula_linha, accumulates the result matrix and flags, pulses done.
// Build option MATRIZ_SATURATE_EN selects saturating element arithmetic.
module controle_operacoes_matriz
  import controle_operacoes_matriz_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  controle_operacoes_matriz_if.slave bus
);

  estado_t                           state_reg;
  logic [ROW_W-1:0]                  row_reg;
  logic [OP_W-1:0]                   op_reg;
  logic [N-1:0][ROW_BITS-1:0]        a_reg;
  logic [N-1:0][ROW_BITS-1:0]        b_reg;
  logic [DATA_W-1:0]                 esc_reg;
  logic [N-1:0][ROW_BITS-1:0]        result_reg;
  logic                              busy_reg;
  logic                              done_reg;
  logic                              ovf_reg;
  logic                              erro_reg;

  logic [ROW_BITS-1:0]               row_res;
  logic                              row_ovf;

  ula_linha u_ula (
    .row_a   (a_reg[row_reg]),
    .row_b   (b_reg[row_reg]),
    .escalar (esc_reg),
    .opcode  (op_reg),
    .row_res (row_res),
    .row_ovf (row_ovf)
  );

  // Sequencer FSM: operand latch, row stepping, result writeback and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      row_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      esc_reg    <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      erro_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            op_reg   <= bus.opcode;
            a_reg    <= bus.matrix_A;
            b_reg    <= bus.matrix_B;
            esc_reg  <= bus.escalar;
            row_reg  <= '0;
            ovf_reg  <= 1'b0;
            busy_reg <= 1'b1;
            if (opcode_valido(bus.opcode)) begin
              erro_reg  <= 1'b0;
              state_reg <= ST_EXEC;
            end else begin
              // Rejected opcode: report and finish without touching result
              erro_reg  <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          result_reg[row_reg] <= row_res;
          if (row_ovf) begin
            ovf_reg <= 1'b1;
          end
          if (row_reg == ROW_W'(N-1)) begin
            row_reg   <= '0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            row_reg <= row_reg + 1'b1;
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.result   = result_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.overflow = ovf_reg;
  assign bus.erro     = erro_reg;

endmodule
